// File: rtl/key_conditioner_pkg.sv
// Shared types and helpers for the key conditioner.
// Holds the repeat-FSM state encoding and the counter-width helper.
package key_conditioner_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      REPEAT = 2'd2
   } rpt_state_t;

   // Width needed to hold values 0..n-1, never less than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/key_chan.sv
// One push-button channel: synchronizer, stability-counter debounce,
// registered press/release pulses and, with KEY_CONDITIONER_REPEAT_EN
// defined, an auto-repeat FSM that adds key_press pulses while held.
//
//  state  | meaning
//  IDLE   | key released or press not yet seen; no repeat pending
//  DELAY  | key held, counting down to the first repeat pulse
//  REPEAT | key held, emitting a pulse every REPEAT_PERIOD clocks
module key_chan
   import key_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int RAW_ACTIVE_LOW  = 1
`ifdef KEY_CONDITIONER_REPEAT_EN
   ,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000
`endif
) (
   input  logic clk,
   input  logic reset_n,
   input  logic key_raw,
   output logic key_level,
   output logic key_press,
   output logic key_release
);

   localparam int CW = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_TC = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic POL = (RAW_ACTIVE_LOW != 0);

   // The polarity flip sits in front of the first flop so that the
   // all-zero reset value of the synchronizer already means "released".
   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;
   logic          commit;
   logic          rise;
   logic          fall;

   // Debounce commit: s has differed from key_level for the full window.
   always_comb begin
      commit = (sync2 != key_level) && (cnt == CNT_TC);
      rise   = commit && sync2;
      fall   = commit && !sync2;
   end

   // Synchronizer, stability counter, debounced level and release pulse.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1       <= 1'b0;
         sync2       <= 1'b0;
         cnt         <= '0;
         key_level   <= 1'b0;
         key_release <= 1'b0;
      end else begin
         sync1       <= key_raw ^ POL;
         sync2       <= sync1;
         key_release <= fall;
         if (sync2 == key_level) begin
            cnt <= '0;
         end else if (cnt == CNT_TC) begin
            cnt       <= '0;
            key_level <= sync2;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

`ifdef KEY_CONDITIONER_REPEAT_EN
   localparam int RW = cnt_width((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
   localparam logic [RW-1:0] RD_LOAD = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] RP_LOAD = RW'(REPEAT_PERIOD - 1);

   rpt_state_t    state;
   logic [RW-1:0] rcnt;

   // Repeat FSM; owns key_press so debounce and repeat pulses share one flop.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         rcnt      <= '0;
         key_press <= 1'b0;
      end else begin
         key_press <= rise;
         case (state)
            IDLE: begin
               if (rise) begin
                  state <= DELAY;
                  rcnt  <= RD_LOAD;
               end
            end
            DELAY, REPEAT: begin
               // A committing release wins over a due repeat pulse.
               if (fall || !key_level) begin
                  state <= IDLE;
                  rcnt  <= '0;
               end else if (rcnt == '0) begin
                  key_press <= 1'b1;
                  state     <= REPEAT;
                  rcnt      <= RP_LOAD;
               end else begin
                  rcnt <= rcnt - RW'(1);
               end
            end
            default: begin
               state <= IDLE;
               rcnt  <= '0;
            end
         endcase
      end
   end
`else
   // Single press pulse on the debounced rising edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         key_press <= 1'b0;
      end else begin
         key_press <= rise;
      end
   end
`endif

endmodule

// File: rtl/key_conditioner.sv
// Multi-key push-button conditioner: N_KEYS independent key_chan instances.
// Define KEY_CONDITIONER_REPEAT_EN to add auto-repeat (REPEAT_DELAY,
// REPEAT_PERIOD parameters); the default build has no repeat logic.
module key_conditioner
   import key_conditioner_pkg::*;
#(
   parameter int N_KEYS          = 2,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int RAW_ACTIVE_LOW  = 1
`ifdef KEY_CONDITIONER_REPEAT_EN
   ,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000
`endif
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [N_KEYS-1:0] key_raw,
   output logic [N_KEYS-1:0] key_level,
   output logic [N_KEYS-1:0] key_press,
   output logic [N_KEYS-1:0] key_release
);

   // One fully independent channel per key.
   for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
      key_chan #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .RAW_ACTIVE_LOW  (RAW_ACTIVE_LOW)
`ifdef KEY_CONDITIONER_REPEAT_EN
         ,
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
      ) u_chan (
         .clk         (clk),
         .reset_n     (reset_n),
         .key_raw     (key_raw[i]),
         .key_level   (key_level[i]),
         .key_press   (key_press[i]),
         .key_release (key_release[i])
      );
   end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=8,
// REPEAT_PERIOD=3, active-low raw keys. Outputs sampled 1 ns after posedge.
module tb_key_conditioner;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [1:0] key_raw;
   logic [1:0] key_level;
   logic [1:0] key_press;
   logic [1:0] key_release;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   key_conditioner #(
      .N_KEYS          (2),
      .DEBOUNCE_CYCLES (4),
      .RAW_ACTIVE_LOW  (1)
`ifdef KEY_CONDITIONER_REPEAT_EN
      ,
      .REPEAT_DELAY    (8),
      .REPEAT_PERIOD   (3)
`endif
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .key_raw     (key_raw),
      .key_level   (key_level),
      .key_press   (key_press),
      .key_release (key_release)
   );

   task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [1:0] rpt_exp(input int k);
`ifdef KEY_CONDITIONER_REPEAT_EN
      return (k == 8 || k == 11 || k == 14 || k == 17) ? 2'b01 : 2'b00;
`else
      return (k == 0) ? 2'b01 : 2'b00;
`endif
   endfunction

   initial begin
      reset_n = 1'b1;
      key_raw = 2'b11;
      #2 reset_n = 1'b0;
      step(2);
      check("rst_level",   key_level,   2'b00);
      check("rst_press",   key_press,   2'b00);
      check("rst_release", key_release, 2'b00);
      reset_n = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         step(1);
         check("idle_level", key_level, 2'b00);
         check("idle_press", key_press, 2'b00);
      end

      // Clean press and release on key 0.
      key_raw = 2'b10;
      for (int k = 1; k <= 6; k++) begin
         step(1);
         check("press_level",   key_level,   (k == 6) ? 2'b01 : 2'b00);
         check("press_pulse",   key_press,   (k == 6) ? 2'b01 : 2'b00);
         check("press_release", key_release, 2'b00);
      end
      step(1);
      check("press_single", key_press, 2'b00);
      check("press_hold",   key_level, 2'b01);
      key_raw = 2'b11;
      for (int k = 1; k <= 6; k++) begin
         step(1);
         check("rel_level", key_level,   (k == 6) ? 2'b00 : 2'b01);
         check("rel_pulse", key_release, (k == 6) ? 2'b01 : 2'b00);
         check("rel_press", key_press,   2'b00);
      end
      step(1);
      check("rel_single", key_release, 2'b00);
      step(3);

      // Bounce: low 3, high 1, low 3, then high.
      for (int i = 0; i < 17; i++) begin
         key_raw[0] = !((i < 3) || (i >= 4 && i < 7));
         step(1);
         check("bounce_level", key_level, 2'b00);
         check("bounce_press", key_press, 2'b00);
      end
      key_raw = 2'b11;
      step(2);

      // Simultaneous press, then release key 1 only.
      key_raw = 2'b00;
      for (int k = 1; k <= 6; k++) begin
         step(1);
         check("sim_level", key_level, (k == 6) ? 2'b11 : 2'b00);
         check("sim_press", key_press, (k == 6) ? 2'b11 : 2'b00);
      end
      step(1);
      check("sim_single", key_press, 2'b00);
      key_raw = 2'b10;
      for (int k = 1; k <= 6; k++) begin
         step(1);
         check("sim_rel_level", key_level,   (k == 6) ? 2'b01 : 2'b11);
         check("sim_rel_pulse", key_release, (k == 6) ? 2'b10 : 2'b00);
         check("sim_rel_press", key_press,   2'b00);
      end
      step(1);
      check("sim_rel_single", key_release, 2'b00);

      // Reset two clocks into a debounce count, both keys held through it.
      key_raw = 2'b00;
      step(2);
      reset_n = 1'b0;
      #1;
      check("mid_rst_level",   key_level,   2'b00);
      check("mid_rst_press",   key_press,   2'b00);
      check("mid_rst_release", key_release, 2'b00);
      for (int k = 1; k <= 2; k++) begin
         step(1);
         check("in_rst_level", key_level, 2'b00);
         check("in_rst_press", key_press, 2'b00);
      end
      reset_n = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         step(1);
         check("post_rst_level",   key_level,   (k == 6) ? 2'b11 : 2'b00);
         check("post_rst_press",   key_press,   (k == 6) ? 2'b11 : 2'b00);
         check("post_rst_release", key_release, 2'b00);
      end
      step(1);
      check("post_rst_single", key_press, 2'b00);
      key_raw = 2'b11;
      for (int k = 1; k <= 6; k++) begin
         step(1);
         check("both_rel_pulse", key_release, (k == 6) ? 2'b11 : 2'b00);
         check("both_rel_press", key_press,   2'b00);
      end
      step(1);
      check("both_rel_single", key_release, 2'b00);
      step(3);

      // Hold key 0 for 20 clocks after key_level rises, release lands at +20.
      key_raw = 2'b10;
      step(6);
      check("rpt_level0", key_level, 2'b01);
      check("rpt_press0", key_press, rpt_exp(0));
      for (int k = 1; k <= 20; k++) begin
         step(1);
         check("rpt_press",   key_press,   rpt_exp(k));
         check("rpt_level",   key_level,   (k == 20) ? 2'b00 : 2'b01);
         check("rpt_release", key_release, (k == 20) ? 2'b01 : 2'b00);
         if (k == 14) key_raw = 2'b11;
      end
      for (int k = 1; k <= 6; k++) begin
         step(1);
         check("rpt_after_press",   key_press,   2'b00);
         check("rpt_after_release", key_release, 2'b00);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
